// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute and drives ALU and
// datapath controls. Defining MC_IMM_LOGIC_EN adds andi/ori (zero-extended) to IMM_EX.
module multicycle_control #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [3:0]         alu_control,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               zero_ext,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    StIdle   = STATE_W'(0),
    StFetch  = STATE_W'(1),
    StDecode = STATE_W'(2),
    StMemAdr = STATE_W'(3),
    StMemRd  = STATE_W'(4),
    StMemWb  = STATE_W'(5),
    StMemWr  = STATE_W'(6),
    StExecR  = STATE_W'(7),
    StAluWb  = STATE_W'(8),
    StBranch = STATE_W'(9),
    StJump   = STATE_W'(10),
    StImmEx  = STATE_W'(11),
    StImmWb  = STATE_W'(12)
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  state_e     state_q, state_d;
  logic       imm_logic;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic [3:0] imm_alu;

`ifdef MC_IMM_LOGIC_EN
  assign imm_logic = (opcode == OpAndi) || (opcode == OpOri);
`else
  assign imm_logic = 1'b0;
`endif

  // Without the logical-immediate feature imm_logic is 0, so zero_ext is tied low.
  assign zero_ext  = (state_q == StImmEx) && imm_logic;
  assign imm_alu   = !imm_logic ? AluAdd : (opcode == OpAndi) ? AluAnd : AluOr;
  assign dbg_state = state_q;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = AluAnd;
    case (funct)
      6'b100000: funct_alu = AluAdd;
      6'b100010: funct_alu = AluSub;
      6'b100100: funct_alu = AluAnd;
      6'b100101: funct_alu = AluOr;
      6'b101010: funct_alu = AluSlt;
      6'b100111: funct_alu = AluNor;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:     state_d = StMemAdr;
          OpRtype:        state_d = StExecR;
          OpBeq:          state_d = StBranch;
          OpJ:            state_d = StJump;
          OpAddi:         state_d = StImmEx;
          OpAndi, OpOri:  state_d = imm_logic ? StImmEx : StFetch;
          default:        state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExecR:  state_d = funct_ok ? StAluWb : StFetch;
      StImmEx:  state_d = StImmWb;
      StMemWb, StAluWb, StBranch, StJump, StImmWb: state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_control = AluAnd;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read    = 1'b1;
        alu_control = AluAdd;
        alu_src_b   = 2'b01;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
      end
      StDecode: begin
        alu_control = AluAdd;
        alu_src_b   = 2'b11;
        // DECODE only falls back to FETCH on an unsupported opcode.
        illegal     = (state_d == StFetch);
      end
      StMemAdr: begin
        alu_control = AluAdd;
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StExecR: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        illegal     = !funct_ok;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_control = AluSub;
        alu_src_a   = 1'b1;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      StJump: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      StImmEx: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = imm_alu;
      end
      StImmWb: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule
